mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage directly downstream of execute. Accepts one op per handshake:
//  ALU result (address or pass-through value), store data and load/store controls.
//  Loads/stores run on a req/gnt/rvalid data bus; ALU-only ops pass straight through.
//  Produces a registered writeback result with valid/ready backpressure. One bus op in flight max.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT before forced error completion; 1..255, 8-bit counter
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high
//  in_valid       in   1   execute presents an op
//  in_ready       out  1   stage accepts op this cycle (in_valid & in_ready = accept)
//  in_alu_result  in   32  address for mem ops, result otherwise
//  in_store_data  in   32  store source (low lanes used for byte/half)
//  in_mem_read    in   1   load; wins if in_mem_write also set
//  in_mem_write   in   1   store
//  in_size        in   2   00 byte, 01 half, 10/11 word
//  in_unsigned    in   1   zero-extend loads (else sign-extend)
//  in_rd          in   5   destination register tag, passed through
//  dmem_req       out  1   bus request; held with addr/we/be/wdata stable until dmem_gnt
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  {addr[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   load data valid; arrives >=1 cycle after gnt
//  dmem_rdata     in   32  load data word
//  out_valid      out  1   writeback result valid; held until out_ready
//  out_ready      in   1   writeback consumes result
//  out_result     out  32  load data (extended), store/ALU: in_alu_result
//  out_rd         out  5   tag of completing op
//  out_err        out  1   bus timeout or (with trap) misaligned access
// BEHAVIOUR
//  - Reset: FSM=IDLE, timeout count=0; out_valid/out_err/dmem_req/dmem_we=0; out_result, out_rd,
//    dmem_addr, dmem_be, dmem_wdata=0. Reset mid-op abandons op; dmem_req drops at once; later
//    rvalid/gnt ignored.
//  - in_ready = (state==IDLE) & (~out_valid | out_ready).
//  - FSM IDLE: accept of non-mem op -> out_* loaded next edge (latency 1, throughput 1/cycle).
//    Accept of mem op -> latch addr/be/wdata/size/unsigned/rd, go REQ (dmem_req=1 next cycle).
//  - REQ: dmem_req=1. On gnt: store -> complete (out_result=address), go IDLE;
//    load -> go WAIT, dmem_req=0 next cycle.
//  - WAIT: on rvalid: select lane by addr[1:0], extend per size/unsigned, complete, go IDLE.
//  - Timeout: counter clears on REQ entry, increments each REQ/WAIT cycle. At TIMEOUT_CYCLES
//    without gnt/rvalid: complete with out_err=1, out_result=0, dmem_req=0, go IDLE.
//  - Lanes: byte be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; half be=addr[1]?1100:0011,
//    wdata={2{d[15:0]}}; word be=1111, wdata=d.
//  - Output slot is free whenever a mem op completes (acceptance required it); no loss possible.
//  - out_err=0 on all normal completions.
// CONFIGURATION
//  MEM_STAGE_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 raises no
//   dmem_req; completes 1 cycle after accept with out_err=1, out_result=address.
//  Not defined: misaligned low address bits ignored (half uses addr[1], word uses addr[31:2]);
//   access proceeds normally, out_err=0.
// TESTING
//  1. ALU op 0x1234, out_ready=1 on 3 back-to-back ops -> out_valid each cycle after accept, no dmem_req.
//  2. Store byte addr 0x103, data 0xAB -> dmem_addr 0x100, be 1000, wdata 0xABABABAB; gnt -> out_result 0x103.
//  3. Load half signed addr 0x102, rdata 0x8001_0000, gnt delayed 3 cycles -> out_result 0xFFFF8001.
//  4. Load with no gnt, TIMEOUT_CYCLES=8 -> dmem_req drops, out_err=1, out_result 0 after 8 REQ cycles.
//  5. Word load addr 0x101 -> trap on: out_err=1, result 0x101, no req; trap off: dmem_addr 0x100.
//  6. Assert reset while in WAIT, then rvalid -> state IDLE, out_valid stays 0, in_ready=1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through or one load/store on a req/gnt/rvalid bus.
// Optional build macro MEM_STAGE_MISALIGN_TRAP_EN turns misaligned half/word accesses into error completions.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [4:0]  r_rd;

  logic        w_accept;
  logic        w_isMem;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  assign in_ready  = (r_state == S_IDLE) & (~out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_isMem   = in_mem_read | in_mem_write;
  assign w_timeout = (r_cnt == LP_LAST);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_misalign = ((in_size == 2'b01) & in_alu_result[0]) |
                      (in_size[1] & (in_alu_result[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_store_data;
    case (in_size)
      2'b00: begin
        w_be    = 4'b0001 << in_alu_result[1:0];
        w_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = in_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select on the returned word, then extend according to the latched size/signedness
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_addr[1:0])
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      2'b11:   w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half     = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_loadData = dmem_rdata;
    case (r_size)
      2'b00:   w_loadData = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loadData = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_addr     <= 32'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_rd       <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_rd     <= 5'd0;
      out_err    <= 1'b0;
    end else begin
      // A completion below overrides this drain; acceptance guarantees the slot is free then
      if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_isMem & ~w_misalign) begin
              r_addr     <= in_alu_result;
              r_size     <= in_size;
              r_unsigned <= in_unsigned;
              r_rd       <= in_rd;
              r_cnt      <= 8'd0;
              dmem_req   <= 1'b1;
              dmem_we    <= ~in_mem_read;
              dmem_addr  <= {in_alu_result[31:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
              r_state    <= S_REQ;
            end else begin
              out_valid  <= 1'b1;
              out_result <= in_alu_result;
              out_rd     <= in_rd;
              out_err    <= w_isMem;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              out_valid  <= 1'b1;
              out_result <= r_addr;
              out_rd     <= r_rd;
              out_err    <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= 32'd0;
            out_rd     <= r_rd;
            out_err    <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            out_valid  <= 1'b1;
            out_result <= w_loadData;
            out_rd     <= r_rd;
            out_err    <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_timeout) begin
            out_valid  <= 1'b1;
            out_result <= 32'd0;
            out_rd     <= r_rd;
            out_err    <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
